// File: rtl/fir_output_scaler_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fir_output_scaler_fifo
// Purpose : Round, rescale and saturate FIR results into a small output FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module fir_output_scaler_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] iv_din,
  input  logic                  i_din_valid,
  output logic                  o_ready,
  output logic [OUT_WIDTH-1:0]  ov_dout,
  output logic                  o_dout_valid,
  input  logic                  i_dout_ready,
  output logic [15:0]           ov_sat_count
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0]   c_FULL    = (c_AW+1)'(FIFO_DEPTH);
  localparam logic [c_AW:0]   c_CNT_ONE = (c_AW+1)'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
  localparam logic signed [DATA_WIDTH:0] c_RND =
    (SHIFT > 0) ? ((DATA_WIDTH+1)'(1) << ((SHIFT > 0) ? (SHIFT-1) : 0)) : '0;
  localparam logic signed [DATA_WIDTH:0] c_MAX = (DATA_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [DATA_WIDTH:0] c_MIN = ~c_MAX;

  logic [OUT_WIDTH-1:0]         r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]              r_wr_ptr;
  logic [c_AW-1:0]              r_rd_ptr;
  logic [c_AW:0]                r_count;
  logic                         r_out_en;
  logic [15:0]                  r_sat_count;

  logic signed [DATA_WIDTH:0]   w_t;
  logic signed [DATA_WIDTH:0]   w_s;
  logic                         w_sat_hi;
  logic                         w_sat_lo;
  logic [OUT_WIDTH-1:0]         w_scaled;
  logic                         w_push;
  logic                         w_pop;

  // Round-half-up then arithmetic shift; one guard bit keeps the add exact.
  always_comb begin
    w_t      = $signed({iv_din[DATA_WIDTH-1], iv_din}) + c_RND;
    w_s      = w_t >>> SHIFT;
    w_sat_hi = (w_s > c_MAX);
    w_sat_lo = (w_s < c_MIN);
    if (w_sat_hi)      w_scaled = c_MAX[OUT_WIDTH-1:0];
    else if (w_sat_lo) w_scaled = c_MIN[OUT_WIDTH-1:0];
    else               w_scaled = w_s[OUT_WIDTH-1:0];
  end

  // r_out_en holds o_ready low through reset and up to the first edge after release.
  assign o_ready      = r_out_en && (r_count != c_FULL);
  assign o_dout_valid = (r_count != '0);
  assign ov_dout      = o_dout_valid ? r_mem[r_rd_ptr] : '0;
  assign ov_sat_count = r_sat_count;

  assign w_push = i_din_valid && o_ready;
  assign w_pop  = o_dout_valid && i_dout_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_en    <= 1'b0;
      r_sat_count <= '0;
    end else begin
      r_out_en <= 1'b1;
      if (i_flush) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_sat_count <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_ONE;
          2'b01:   r_count <= r_count - c_CNT_ONE;
          default: r_count <= r_count;
        endcase
        if (w_push && (w_sat_hi || w_sat_lo) && (r_sat_count != 16'hFFFF))
          r_sat_count <= r_sat_count + 16'd1;
      end
    end
  end

  // Storage carries no reset; contents are only observable once count says so.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= w_scaled;
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_output_scaler_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_fir_output_scaler_fifo
// Purpose : Directed vector table plus hand-written multi-cycle sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fir_output_scaler_fifo;

  typedef struct {
    logic [23:0] din;
    logic [15:0] dout;
    logic [15:0] sat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [23:0] din;
  logic        din_valid;
  logic        o_ready;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] sat_count;

  int n_vec = 0;
  int n_bad = 0;

  vec_t vecs[10];

  fir_output_scaler_fifo #(
    .DATA_WIDTH(24), .OUT_WIDTH(16), .SHIFT(8), .FIFO_DEPTH(4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .iv_din      (din),
    .i_din_valid (din_valid),
    .o_ready     (o_ready),
    .ov_dout     (dout),
    .o_dout_valid(dout_valid),
    .i_dout_ready(dout_ready),
    .ov_sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    vecs[0] = '{24'h000180, 16'h0002, 16'd0};
    vecs[1] = '{24'hFFFE80, 16'hFFFF, 16'd0};
    vecs[2] = '{24'h00007F, 16'h0000, 16'd0};
    vecs[3] = '{24'h000080, 16'h0001, 16'd0};
    vecs[4] = '{24'hFFFF80, 16'h0000, 16'd0};
    vecs[5] = '{24'hFFFF7F, 16'hFFFF, 16'd0};
    vecs[6] = '{24'h7FFFFF, 16'h7FFF, 16'd1};
    vecs[7] = '{24'h800000, 16'h8000, 16'd1};
    vecs[8] = '{24'h7FFF7F, 16'h7FFF, 16'd1};
    vecs[9] = '{24'h7FFF80, 16'h7FFF, 16'd2};

    rst_n = 1'b0; flush = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;

    // Reset state, before any clock edge
    #2;
    chk("rst_ready", o_ready, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_sat", sat_count, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rel_ready_pre_edge", o_ready, 0);
    @(posedge clk); #1 chk("rel_ready_first_edge", o_ready, 1);

    // Table-driven rounding and saturation vectors
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      din = vecs[i].din; din_valid = 1'b1; dout_ready = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), dout_valid, 1);
      chk($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
      chk($sformatf("vec%0d_sat", i), sat_count, vecs[i].sat);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_drained", i), dout_valid, 0);
    end

    // Back-pressure fill and drain
    @(negedge clk); dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); din = 24'((k+1)*10*256); din_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("bp_full_ready", o_ready, 0);
    chk("bp_head", dout, 16'd10);
    @(negedge clk); din = 24'(50*256); din_valid = 1'b1;
    @(posedge clk); #1 chk("bp_fifth_blocked", o_ready, 0);
    @(negedge clk); din_valid = 1'b0; dout_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_out%0d", k), dout, 32'((k+1)*10));
      @(posedge clk); #1;
      if (k == 0) chk("bp_ready_after_pop", o_ready, 1);
      @(negedge clk);
    end
    chk("bp_empty", dout_valid, 0);

    // Streaming: one in, one out every cycle
    for (int i = 0; i < 100; i++) begin
      int v;
      v = i*37 - 1800;
      @(negedge clk); din = 24'(v*256); din_valid = 1'b1; dout_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("stream%0d", i), {o_ready, dout_valid, dout}, {1'b1, 1'b1, 16'(v)});
    end
    @(negedge clk); din_valid = 1'b0;
    @(posedge clk); #1 chk("stream_drained", dout_valid, 0);

    // Saturation counter sticks at 0xFFFF
    @(negedge clk); din = 24'h7FFFFF; din_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1 chk("sat_sticky", sat_count, 16'hFFFF);
    @(negedge clk); din_valid = 1'b0;
    @(posedge clk); #1 chk("sat_drained", dout_valid, 0);

    // Flush with two samples buffered and a third presented
    @(negedge clk); dout_ready = 1'b0; din = 24'h000100; din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); din = 24'h000200;
    @(posedge clk); #1 chk("pre_flush_valid", dout_valid, 1);
    @(negedge clk); flush = 1'b1; din = 24'h7FFFFF;
    @(posedge clk); #1;
    chk("flush_valid", dout_valid, 0);
    chk("flush_sat", sat_count, 0);
    chk("flush_ready", o_ready, 1);
    @(negedge clk); flush = 1'b0; din_valid = 1'b0;
    @(posedge clk); #1 chk("flush_dropped", dout_valid, 0);

    // Async reset between edges with three entries buffered
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); din = 24'((k+1)*256); din_valid = 1'b1;
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    chk("pre_rst_head", dout, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", dout_valid, 0);
    chk("arst_ready", o_ready, 0);
    chk("arst_dout", dout, 0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("arst_rel_ready_pre", o_ready, 0);
    @(posedge clk); #1 chk("arst_rel_ready", o_ready, 1);
    @(negedge clk); din = 24'h000180; din_valid = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk("arst_first_valid", dout_valid, 1);
    chk("arst_first_dout", dout, 16'h0002);
    chk("arst_first_sat", sat_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
